// File: rtl/axil_slave_read_pipelined.sv
// rtl/axil_slave_read_pipelined.sv - AXI4-Lite read front end with credit-limited response FIFO
// Optional feature macro: AXIL_RD_PROT_CHECK_EN (reject unprivileged reads with SLVERR)
module axil_slave_read_pipelined #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              S_AXIL_ACLK,
  input  logic              S_AXIL_ARESETn,
  input  logic              S_AXIL_ARVALID,
  output logic              S_AXIL_ARREADY,
  input  logic [ADDR_W-1:0] S_AXIL_ARADDR,
  input  logic [2:0]        S_AXIL_ARPROT,
  output logic              S_AXIL_RVALID,
  input  logic              S_AXIL_RREADY,
  output logic [DATA_W-1:0] S_AXIL_RDATA,
  output logic [1:0]        S_AXIL_RRESP,
  output logic              user_port_arvalid,
  input  logic              user_port_arready,
  output logic [ADDR_W-1:0] user_port_araddr,
  input  logic              user_port_rvalid,
  input  logic [DATA_W-1:0] user_port_rdata,
  input  logic [1:0]        user_port_rresp,
  output logic [CNT_W-1:0]  rd_outstanding
);

  // Pointers carry one extra bit so full and empty are distinguishable.
  localparam int PW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int EW = DATA_W + 2;

  logic              arready_en;
  logic              hold_valid;
  logic [ADDR_W-1:0] hold_addr;
  logic [CNT_W-1:0]  outstanding;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [EW-1:0]     mem [MAX_OUTSTANDING];
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rd_idx;
  logic              fifo_empty;
  logic              fifo_full;
  logic              credit_ok;
  logic              rejected;
  logic              ar_hs;
  logic              r_hs;
  logic              forward;
  logic              rej_push;
  logic              drop;
  logic              push;
  logic [EW-1:0]     push_entry;
  logic              unused_prot;

  assign unused_prot = ^S_AXIL_ARPROT;

  assign wr_idx     = IW'(wr_ptr % PW'(MAX_OUTSTANDING));
  assign rd_idx     = IW'(rd_ptr % PW'(MAX_OUTSTANDING));
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (PW'(wr_ptr - rd_ptr) == PW'(MAX_OUTSTANDING));
  assign credit_ok  = (outstanding < CNT_W'(MAX_OUTSTANDING));

`ifdef AXIL_RD_PROT_CHECK_EN
  // Unprivileged reads wait until the pipe is empty so their SLVERR lands in order.
  assign rejected       = !S_AXIL_ARPROT[0];
  assign S_AXIL_ARREADY = arready_en && !hold_valid && credit_ok &&
                          (!rejected || (outstanding == '0));
`else
  assign rejected       = 1'b0;
  assign S_AXIL_ARREADY = arready_en && !hold_valid && credit_ok;
`endif

  assign ar_hs    = S_AXIL_ARVALID && S_AXIL_ARREADY;
  assign r_hs     = S_AXIL_RVALID && S_AXIL_RREADY;
  assign forward  = ar_hs && !rejected;
  assign rej_push = ar_hs && rejected;

  // A user response with nothing outstanding or no room is a user protocol error.
  assign drop       = user_port_rvalid && (fifo_full || (outstanding == '0));
  assign push       = (user_port_rvalid && !drop) || rej_push;
  assign push_entry = rej_push ? {{DATA_W{1'b0}}, 2'b10} : {user_port_rdata, user_port_rresp};

  assign user_port_arvalid = hold_valid;
  assign user_port_araddr  = hold_addr;
  assign rd_outstanding    = outstanding;
  assign S_AXIL_RVALID     = !fifo_empty;
  assign {S_AXIL_RDATA, S_AXIL_RRESP} = fifo_empty ? '0 : mem[rd_idx];

  // Keep ARREADY low through reset and for the first cycle after it.
  always_ff @(posedge S_AXIL_ACLK or negedge S_AXIL_ARESETn) begin
    if (!S_AXIL_ARESETn) arready_en <= 1'b0;
    else                 arready_en <= 1'b1;
  end

  // Single-entry address holding register presented to the user device.
  always_ff @(posedge S_AXIL_ACLK or negedge S_AXIL_ARESETn) begin
    if (!S_AXIL_ARESETn) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
    end else if (forward) begin
      hold_valid <= 1'b1;
      hold_addr  <= S_AXIL_ARADDR;
    end else if (hold_valid && user_port_arready) begin
      hold_valid <= 1'b0;
    end
  end

  // Credit counter: reads accepted on AR and not yet completed on R.
  always_ff @(posedge S_AXIL_ACLK or negedge S_AXIL_ARESETn) begin
    if (!S_AXIL_ARESETn) begin
      outstanding <= '0;
    end else begin
      case ({ar_hs, r_hs})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Response FIFO pointers; push and pop may coincide.
  always_ff @(posedge S_AXIL_ACLK or negedge S_AXIL_ARESETn) begin
    if (!S_AXIL_ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(r_hs);
    end
  end

  // Response FIFO storage; contents are don't-care while empty.
  always_ff @(posedge S_AXIL_ACLK) begin
    if (push) mem[wr_idx] <= push_entry;
  end

`ifndef SYNTHESIS
  // Report user responses that had to be dropped.
  always_ff @(posedge S_AXIL_ACLK) begin
    if (S_AXIL_ARESETn && drop)
      $error("axil_slave_read_pipelined: user_port_rvalid with FIFO full or nothing outstanding");
  end
`endif

endmodule

// File: tb/tb_axil_slave_read_pipelined.sv
// tb/tb_axil_slave_read_pipelined.sv - scoreboard bench for axil_slave_read_pipelined
module tb_axil_slave_read_pipelined;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAXO   = 4;
  localparam int CNT_W  = $clog2(MAXO + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [ADDR_W-1:0] araddr = '0;
  logic [2:0]        arprot = 3'b001;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              u_arvalid;
  logic              u_arready = 1'b1;
  logic [ADDR_W-1:0] u_araddr;
  logic              u_rvalid = 1'b0;
  logic [DATA_W-1:0] u_rdata = '0;
  logic [1:0]        u_rresp = '0;
  logic [CNT_W-1:0]  outst;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int lat = 3;
  int ar_cnt = 0;
  int ua_cnt = 0;
  int ar_before;
  int ua_before;
  bit done56 = 1'b0;

  logic [DATA_W+1:0] exp_q[$];
  logic [DATA_W-1:0] ud_q[$];
  int                due_q[$];
  logic              prev_stall = 1'b0;
  logic [DATA_W+1:0] prev_beat = '0;

  always #5 clk = ~clk;

  axil_slave_read_pipelined #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)
  ) dut (
    .S_AXIL_ACLK(clk), .S_AXIL_ARESETn(rst_n),
    .S_AXIL_ARVALID(arvalid), .S_AXIL_ARREADY(arready),
    .S_AXIL_ARADDR(araddr), .S_AXIL_ARPROT(arprot),
    .S_AXIL_RVALID(rvalid), .S_AXIL_RREADY(rready),
    .S_AXIL_RDATA(rdata), .S_AXIL_RRESP(rresp),
    .user_port_arvalid(u_arvalid), .user_port_arready(u_arready),
    .user_port_araddr(u_araddr), .user_port_rvalid(u_rvalid),
    .user_port_rdata(u_rdata), .user_port_rresp(u_rresp),
    .rd_outstanding(outst)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // User device: responds in order, lat cycles after each accepted request.
  always @(posedge clk) begin
    #1;
    u_rvalid = 1'b0;
    if (rst_n && due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      u_rvalid = 1'b1;
      u_rdata  = (ud_q.size() > 0) ? ud_q.pop_front() : 32'hBAD0BAD0;
      u_rresp  = 2'b00;
    end
  end

  // Monitor: handshake counters, R-channel scoreboard and stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (arvalid && arready) ar_cnt++;
      if (u_arvalid && u_arready) begin
        ua_cnt++;
        due_q.push_back(cyc + 1 + lat);
      end
      if (prev_stall) begin
        chk("r_hold_valid", 64'(rvalid), 64'd1);
        chk("r_hold_data", 64'({rdata, rresp}), 64'(prev_beat));
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) chk("r_unexpected_beat", 64'(exp_q.size()), 64'd1);
        else chk("r_beat", 64'({rdata, rresp}), 64'(exp_q.pop_front()));
      end
      prev_stall = rvalid && !rready;
      prev_beat  = {rdata, rresp};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic ar_send(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = a; arprot = p;
    ud_q.push_back(d);
    exp_q.push_back({d, 2'b00});
    do begin @(negedge clk); n++; end while (!arready && n < 300);
    chk("ar_accept", 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((due_q.size() != 0 || u_rvalid || u_arvalid) && n < 200) begin
      @(posedge clk); #2; n++;
    end
    chk("idle_in_time", 64'(n < 200), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk); #1;
    rready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    rready = 1'b0;
    chk("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_u_arvalid", 64'(u_arvalid), 64'd0);
    chk("rst_u_araddr", 64'(u_araddr), 64'd0);
    chk("rst_outst", 64'(outst), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_arready", 64'(arready), 64'd1);

    // Single read with latency check
    lat = 3;
    ar_send(32'h10, 3'b001, 32'hDEADBEEF);
    chk("single_u_arvalid", 64'(u_arvalid), 64'd1);
    chk("single_u_araddr", 64'(u_araddr), 64'h10);
    n = 0;
    do begin @(negedge clk); n++; end while (!u_rvalid && n < 50);
    chk("single_u_rvalid_seen", 64'(u_rvalid), 64'd1);
    chk("single_rvalid_not_early", 64'(rvalid), 64'd0);
    @(negedge clk);
    chk("single_rvalid_latency", 64'(rvalid), 64'd1);
    chk("single_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("single_rresp", 64'(rresp), 64'd0);
    chk("single_outst_pending", 64'(outst), 64'd1);
    drain();
    chk("single_outst_done", 64'(outst), 64'd0);

    // Credit limit: four accepted, fifth and sixth stall until R drains
    lat = 2;
    ar_before = ar_cnt;
    ua_before = ua_cnt;
    for (int i = 0; i < 4; i++) ar_send(32'h100 + 32'(4 * i), 3'b001, 32'h1000 + 32'(i));
    wait_idle();
    chk("credit_outst", 64'(outst), 64'd4);
    chk("credit_arready_low", 64'(arready), 64'd0);
    chk("credit_fifo_nonempty", 64'(rvalid), 64'd1);
    fork
      begin
        ar_send(32'h110, 3'b001, 32'h1004);
        ar_send(32'h114, 3'b001, 32'h1005);
        done56 = 1'b1;
      end
    join_none
    repeat (10) @(posedge clk);
    #1;
    chk("credit_ar_hs_count", 64'(ar_cnt - ar_before), 64'd4);
    chk("credit_user_resp_count", 64'(ua_cnt - ua_before), 64'd4);
    chk("credit_still_blocked", 64'(arready), 64'd0);
    drain();
    n = 0;
    while (!done56 && n < 100) begin @(posedge clk); #1; n++; end
    chk("credit_late_accepted", 64'(done56), 64'd1);
    drain();
    chk("credit_ar_hs_total", 64'(ar_cnt - ar_before), 64'd6);

    // R back-pressure with RREADY toggling
    lat = 1;
    for (int i = 1; i <= 3; i++) ar_send(32'h200 + 32'(4 * i), 3'b001, 32'(i));
    wait_idle();
    chk("bp_outst", 64'(outst), 64'd3);
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; rready = ~rready; end
    rready = 1'b0;
    chk("bp_all_returned", 64'(exp_q.size()), 64'd0);

    // Simultaneous AR and R handshakes, then push and pop together
    lat = 2;
    ar_send(32'h300, 3'b001, 32'hA1);
    ar_send(32'h304, 3'b001, 32'hA2);
    wait_idle();
    chk("sim_outst_before", 64'(outst), 64'd2);
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 32'h308; arprot = 3'b001; rready = 1'b1;
    ud_q.push_back(32'hA3);
    exp_q.push_back({32'hA3, 2'b00});
    @(negedge clk);
    chk("sim_both_ready", 64'({arready, rvalid}), 64'b11);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b0;
    chk("sim_outst_after", 64'(outst), 64'd2);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!u_rvalid && n < 50);
    chk("sim_push_seen", 64'(u_rvalid), 64'd1);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("sim_fifo_one_rvalid", 64'(rvalid), 64'd1);
    chk("sim_fifo_one_outst", 64'(outst), 64'd1);
    chk("sim_head_advanced", 64'({rdata, rresp}), 64'({32'hA3, 2'b00}));
    drain();

    // Asynchronous reset mid-operation
    lat = 1;
    for (int i = 0; i < 3; i++) ar_send(32'h400 + 32'(4 * i), 3'b001, 32'hB0 + 32'(i));
    wait_idle();
    chk("rst_pre_outst", 64'(outst), 64'd3);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_arready", 64'(arready), 64'd0);
    chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
    chk("rst_mid_rdata", 64'(rdata), 64'd0);
    chk("rst_mid_rresp", 64'(rresp), 64'd0);
    chk("rst_mid_u_arvalid", 64'(u_arvalid), 64'd0);
    chk("rst_mid_u_araddr", 64'(u_araddr), 64'd0);
    chk("rst_mid_outst", 64'(outst), 64'd0);
    exp_q.delete();
    ud_q.delete();
    due_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    lat = 3;
    ar_send(32'h20, 3'b001, 32'hCAFEF00D);
    drain();
    chk("post_rst_outst", 64'(outst), 64'd0);

`ifdef AXIL_RD_PROT_CHECK_EN
    // Unprivileged read waits for the pipe to empty and returns SLVERR
    lat = 6;
    ua_before = ua_cnt;
    rready = 1'b1;
    ar_send(32'h30, 3'b001, 32'h5555AAAA);
    rready = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 32'h34; arprot = 3'b000;
    exp_q.push_back({32'h0, 2'b10});
    n = 0;
    do begin
      @(negedge clk); n++;
      if (outst != '0) chk("prot_blocked", 64'(arready), 64'd0);
    end while (!arready && n < 100);
    chk("prot_accept", 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    drain();
    chk("prot_user_req_count", 64'(ua_cnt - ua_before), 64'd1);
    chk("prot_outst_done", 64'(outst), 64'd0);
`endif

    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("final_outst", 64'(outst), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axil_slave_read_pipelined.md
Name: axil_slave_read_pipelined

Overview:
AXI4-Lite slave read-channel front end with a parametrised address/data width and up to MAX_OUTSTANDING reads in flight. It sits between the AXI-Lite interconnect and a user register/memory device. It registers accepted read addresses toward the user port and buffers the user's in-order read responses in a response FIFO that drains onto the R channel. Credit-based flow control guarantees the response FIFO never overflows.

Parameters:
ADDR_W, 32, width of ARADDR and user_port_araddr
DATA_W, 32, width of RDATA and user_port_rdata; must be 32 or 64
MAX_OUTSTANDING, 4, response FIFO depth and credit limit; power of 2, minimum 1, maximum 16
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter

Ports:
S_AXIL_ACLK  in  1  clock, all logic on rising edge
S_AXIL_ARESETn  in  1  asynchronous active-low reset
S_AXIL_ARVALID  in  1  read address valid
S_AXIL_ARREADY  out  1  read address ready
S_AXIL_ARADDR  in  ADDR_W  read address
S_AXIL_ARPROT  in  3  protection attributes
S_AXIL_RVALID  out  1  read data valid
S_AXIL_RREADY  in  1  read data ready
S_AXIL_RDATA  out  DATA_W  read data
S_AXIL_RRESP  out  2  read response
user_port_arvalid  out  1  request valid to user device
user_port_arready  in  1  user device accepts request
user_port_araddr  out  ADDR_W  request address
user_port_rvalid  in  1  one-cycle response strobe, in request order, never back-pressured
user_port_rdata  in  DATA_W  response data
user_port_rresp  in  2  response code
rd_outstanding  out  CNT_W  reads accepted on AR but not yet completed on R

Behaviour:
- Reset (async assert, sync deassert is the integrator's responsibility): ARREADY=0, RVALID=0, RDATA=0, RRESP=0, user_port_arvalid=0, user_port_araddr=0, rd_outstanding=0, FIFO empty. Reset mid-transaction discards all in-flight state. User responses that arrive after reset are ignored while rd_outstanding=0.
- Address holding register (1 entry). S_AXIL_ARREADY = !hold_valid && (rd_outstanding < MAX_OUTSTANDING). ARREADY is combinational from registers only and never depends on ARVALID.
- AR handshake (ARVALID&&ARREADY) at edge N: hold_valid=1 and user_port_araddr=ARADDR from N, so user_port_arvalid is high in cycle N+1. rd_outstanding increments.
- User request: user_port_arvalid=hold_valid. Address and valid stay stable until user_port_arready is sampled high; hold_valid then clears. There is no back-to-back issue from the same entry, so the maximum user request rate is 1 per 2 cycles.
- Response FIFO: push on user_port_rvalid (data, resp). Pop on RVALID&&RREADY. RVALID = !empty. RDATA/RRESP show the FIFO head and are held stable while RVALID&&!RREADY. Latency is user_port_rvalid at edge K → RVALID at K+1 (registered). Push and pop in the same cycle: the count is unchanged and the head advances.
- rd_outstanding: +1 on AR handshake, -1 on R handshake; both in the same cycle leaves it unchanged. It never exceeds MAX_OUTSTANDING.
- Overflow/underflow: user_port_rvalid with the FIFO full, or with no request outstanding, is a protocol violation by the user. The push is dropped, and a simulation-only $error fires.
- Pointers wrap modulo MAX_OUTSTANDING. Full/empty are distinguished by an extra pointer bit.

Optional Feature:
AXIL_RD_PROT_CHECK_EN
- Defined: a request with ARPROT[0]==0 (unprivileged) is rejected.
  - While a rejected request is at ARVALID, ARREADY is forced low until rd_outstanding==0. It is then accepted.
  - The rejected request is not forwarded to the user. An entry {RDATA=0, RRESP=2'b10 SLVERR} is pushed directly into the FIFO on the accept edge, preserving response order.
  - rd_outstanding counts the rejected request like any other.
- Undefined: ARPROT is ignored and every request is forwarded.

Test Plan:
- Single read: ARADDR=0x10, user arready on the first cycle, user rvalid 3 cycles later with rdata=0xDEADBEEF rresp=0. Required: RVALID one cycle after rvalid, RDATA=0xDEADBEEF, RRESP=0, rd_outstanding returns to 0.
- Credit limit: MAX_OUTSTANDING=4, RREADY=0, issue 6 ARs, and the user responds to each. Required: exactly 4 AR handshakes, ARREADY low after the 4th, and 4 entries in the FIFO. Then RREADY=1 lets the remaining 2 be accepted. All 6 data words are returned in order.
- R back-pressure: RREADY toggles 1/0 each cycle while 3 responses (0x1,0x2,0x3) are queued. Required: RDATA is stable whenever RVALID&&!RREADY, order is 1,2,3, and no loss.
- Simultaneous events: an AR handshake and an R handshake in the same cycle with rd_outstanding=2. Required: rd_outstanding stays 2. A push and pop in the same cycle with one entry queued leaves the FIFO count at 1.
- Reset mid-operation: assert ARESETn=0 with 3 outstanding and RVALID=1. Required: all outputs are 0 immediately (asynchronous, no clock edge). After release, a fresh read returns correct data.
- With AXIL_RD_PROT_CHECK_EN: send ARPROT=3'b001 (accepted), then ARPROT=3'b000 while the first is pending. Required: the second waits for the first R handshake, then RRESP=2'b10 and RDATA=0, and user_port_arvalid never pulses for the second.
